// File: rtl/ws_excp_commit_if.sv
// MEM->WB instruction bundle with valid/allow_in handshake.
// master: MEM-stage register side; slave: WB commit unit.
interface ws_excp_commit_if;
    logic        ms_to_ws_valid;
    logic        ws_allow_in;
    logic [31:0] ms_pc;
    logic        ms_bd;
    logic        ms_excp;
    logic [4:0]  ms_excode;
    logic        ms_eret;
    logic        ms_mtc0;
    logic        ms_mfc0;
    logic [7:0]  ms_cp0_addr;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_bd, ms_excp, ms_excode,
        output ms_eret, ms_mtc0, ms_mfc0, ms_cp0_addr, ms_dest,
        output ms_result,
        input  ws_allow_in
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_bd, ms_excp, ms_excode,
        input  ms_eret, ms_mtc0, ms_mfc0, ms_cp0_addr, ms_dest,
        input  ms_result,
        output ws_allow_in
    );
endinterface

// File: rtl/ws_excp_commit.sv
// WB commit unit: regfile/MTC0 writes, exception and ERET commit,
// one-cycle pipeline flush with redirect PC, saturating exception count.
// Ports: clk, reset (sync, high), ms (MEM->WB bundle, slave),
//   i_cp0_rdata/i_cp0_epc from cp0, o_cp0_* to cp0, o_rf_* to regfile,
//   o_flush/o_flush_pc to fs/ds/es/ms, o_excp_cnt.
module ws_excp_commit #(
    parameter logic [31:0] EXC_ENTRY = 32'hbfc00380,
    parameter int          CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    ws_excp_commit_if.slave      ms,
    input  logic [31:0]          i_cp0_rdata,
    input  logic [31:0]          i_cp0_epc,
    output logic                 o_cp0_we,
    output logic [7:0]           o_cp0_addr,
    output logic [31:0]          o_cp0_wdata,
    output logic                 o_cp0_excp_valid,
    output logic [4:0]           o_cp0_excode,
    output logic [31:0]          o_cp0_pc,
    output logic                 o_cp0_bd,
    output logic                 o_cp0_eret,
    output logic                 o_rf_we,
    output logic [4:0]           o_rf_waddr,
    output logic [31:0]          o_rf_wdata,
    output logic                 o_flush,
    output logic [31:0]          o_flush_pc,
    output logic [CNT_W-1:0]     o_excp_cnt
);

    typedef enum logic [0:0] {
        S_RUN,
        S_FLUSH
    } state_t;

    state_t            r_state;
    logic              r_ws_valid;
    logic [31:0]       r_pc;
    logic              r_bd;
    logic              r_excp;
    logic [4:0]        r_excode;
    logic              r_eret;
    logic              r_mtc0;
    logic              r_mfc0;
    logic [7:0]        r_cp0_addr;
    logic [4:0]        r_dest;
    logic [31:0]       r_result;
    logic              r_flush;
    logic [31:0]       r_flush_pc;
    logic [CNT_W-1:0]  r_excp_cnt;

    logic w_run;
    logic w_live;
    logic w_exc;
    logic w_eret;
    logic w_norm;
    logic w_redirect;
    logic w_take;

    assign w_run      = (r_state == S_RUN);
    assign w_live     = r_ws_valid && w_run;
    assign w_exc      = w_live && r_excp;
    assign w_eret     = w_live && !r_excp && r_eret;
    assign w_norm     = w_live && !r_excp && !r_eret;
    assign w_redirect = w_exc || w_eret;
    // The instruction behind a redirecting commit is younger and is
    // dropped here rather than waiting for the flush to reach MEM.
    assign w_take     = w_run && ms.ms_to_ws_valid && !w_redirect;

    assign ms.ws_allow_in = w_run;

    assign o_cp0_excp_valid = w_exc;
    assign o_cp0_excode     = r_excode;
    assign o_cp0_pc         = r_pc;
    assign o_cp0_bd         = r_bd;
    assign o_cp0_eret       = w_eret;
    assign o_cp0_we         = w_norm && r_mtc0;
    assign o_cp0_addr       = r_cp0_addr;
    assign o_cp0_wdata      = r_result;
    assign o_rf_we          = w_norm && (r_dest != 5'd0) && !r_mtc0;
    assign o_rf_waddr       = r_dest;
    assign o_rf_wdata       = r_mfc0 ? i_cp0_rdata : r_result;
    assign o_flush          = r_flush;
    assign o_flush_pc       = r_flush_pc;
    assign o_excp_cnt       = r_excp_cnt;

    // Control FSM with registered flush outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_ws_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_flush_pc <= 32'd0;
            r_excp_cnt <= '0;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (w_redirect) begin
                        r_state    <= S_FLUSH;
                        r_ws_valid <= 1'b0;
                        r_flush    <= 1'b1;
                        // EPC is sampled in the ERET commit cycle, so an
                        // MTC0 EPC one cycle earlier is already visible.
                        r_flush_pc <= w_exc ? EXC_ENTRY : i_cp0_epc;
                        if (w_exc && (r_excp_cnt != {CNT_W{1'b1}})) begin
                            r_excp_cnt <= r_excp_cnt + 1'b1;
                        end
                    end else begin
                        r_flush    <= 1'b0;
                        r_ws_valid <= ms.ms_to_ws_valid;
                    end
                end
                S_FLUSH: begin
                    r_state    <= S_RUN;
                    r_flush    <= 1'b0;
                    r_ws_valid <= 1'b0;
                end
                default: begin
                    r_state    <= S_RUN;
                    r_flush    <= 1'b0;
                    r_ws_valid <= 1'b0;
                end
            endcase
        end
    end

    // MEM->WB payload register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= 32'd0;
            r_bd       <= 1'b0;
            r_excp     <= 1'b0;
            r_excode   <= 5'd0;
            r_eret     <= 1'b0;
            r_mtc0     <= 1'b0;
            r_mfc0     <= 1'b0;
            r_cp0_addr <= 8'd0;
            r_dest     <= 5'd0;
            r_result   <= 32'd0;
        end else if (w_take) begin
            r_pc       <= ms.ms_pc;
            r_bd       <= ms.ms_bd;
            r_excp     <= ms.ms_excp;
            r_excode   <= ms.ms_excode;
            r_eret     <= ms.ms_eret;
            r_mtc0     <= ms.ms_mtc0;
            r_mfc0     <= ms.ms_mfc0;
            r_cp0_addr <= ms.ms_cp0_addr;
            r_dest     <= ms.ms_dest;
            r_result   <= ms.ms_result;
        end
    end

endmodule

// File: tb/tb_ws_excp_commit.sv
// Scoreboard bench for ws_excp_commit: stimulus queues expected commits
// and flushes, a negedge monitor pops and compares on each DUT strobe.
module tb_ws_excp_commit;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic              clk;
    logic              reset;
    logic [31:0]       cp0_rdata;
    logic [31:0]       cp0_epc;
    logic              cp0_we;
    logic [7:0]        cp0_addr;
    logic [31:0]       cp0_wdata;
    logic              cp0_excp_valid;
    logic [4:0]        cp0_excode;
    logic [31:0]       cp0_pc;
    logic              cp0_bd;
    logic              cp0_eret;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic              flush_o;
    logic [31:0]       flush_pc;
    logic [CNT_W-1:0]  excp_cnt;

    ws_excp_commit_if ms_if();

    ws_excp_commit #(
        .EXC_ENTRY (32'hbfc00380),
        .CNT_W     (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ms               (ms_if.slave),
        .i_cp0_rdata      (cp0_rdata),
        .i_cp0_epc        (cp0_epc),
        .o_cp0_we         (cp0_we),
        .o_cp0_addr       (cp0_addr),
        .o_cp0_wdata      (cp0_wdata),
        .o_cp0_excp_valid (cp0_excp_valid),
        .o_cp0_excode     (cp0_excode),
        .o_cp0_pc         (cp0_pc),
        .o_cp0_bd         (cp0_bd),
        .o_cp0_eret       (cp0_eret),
        .o_rf_we          (rf_we),
        .o_rf_waddr       (rf_waddr),
        .o_rf_wdata       (rf_wdata),
        .o_flush          (flush_o),
        .o_flush_pc       (flush_pc),
        .o_excp_cnt       (excp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal cp0 EPC register (addr {14,0}).
    always @(posedge clk) begin
        if (reset) cp0_epc <= 32'd0;
        else if (cp0_we === 1'b1 && cp0_addr == 8'h70) cp0_epc <= cp0_wdata;
    end

    typedef struct {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        cp0_we;
        logic        chk_addr;
        logic [7:0]  addr;
        logic [31:0] cwdata;
        logic        exc;
        logic [4:0]  excode;
        logic [31:0] pc;
        logic        bd;
        logic        eret;
    } commit_t;

    typedef struct {
        logic [31:0]      pc;
        logic [CNT_W-1:0] cnt;
    } flush_t;

    commit_t commit_q[$];
    flush_t  flush_q[$];
    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic commit_t mk(
        input logic rw, input logic [4:0] wa, input logic [31:0] wd,
        input logic cw, input logic ca, input logic [7:0] ad,
        input logic [31:0] cd, input logic ex, input logic [4:0] ec,
        input logic [31:0] pc, input logic bd, input logic er);
        commit_t c;
        c.rf_we = rw; c.waddr = wa; c.wdata = wd;
        c.cp0_we = cw; c.chk_addr = ca; c.addr = ad; c.cwdata = cd;
        c.exc = ex; c.excode = ec; c.pc = pc; c.bd = bd; c.eret = er;
        return c;
    endfunction

    function automatic flush_t mkf(input logic [31:0] pc,
                                   input logic [CNT_W-1:0] cnt);
        flush_t f;
        f.pc = pc; f.cnt = cnt;
        return f;
    endfunction

    task automatic bump_cnt();
        if (exp_cnt != CMAX) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic set_ms(
        input logic [31:0] pc, input logic bd, input logic ex,
        input logic [4:0] ec, input logic er, input logic mt,
        input logic mf, input logic [7:0] ad, input logic [4:0] dst,
        input logic [31:0] res);
        ms_if.ms_pc       = pc;
        ms_if.ms_bd       = bd;
        ms_if.ms_excp     = ex;
        ms_if.ms_excode   = ec;
        ms_if.ms_eret     = er;
        ms_if.ms_mtc0     = mt;
        ms_if.ms_mfc0     = mf;
        ms_if.ms_cp0_addr = ad;
        ms_if.ms_dest     = dst;
        ms_if.ms_result   = res;
    endtask

    task automatic send(
        input logic [31:0] pc, input logic bd, input logic ex,
        input logic [4:0] ec, input logic er, input logic mt,
        input logic mf, input logic [7:0] ad, input logic [4:0] dst,
        input logic [31:0] res);
        set_ms(pc, bd, ex, ec, er, mt, mf, ad, dst, res);
        ms_if.ms_to_ws_valid = 1'b1;
        @(posedge clk); #1;
        ms_if.ms_to_ws_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe must match the oldest expected record.
    always @(negedge clk) begin
        commit_t c;
        flush_t  f;
        if (rf_we === 1'b1 || cp0_we === 1'b1 ||
            cp0_excp_valid === 1'b1 || cp0_eret === 1'b1) begin
            if (commit_q.size() == 0) begin
                chk("unexpected_commit",
                    {60'd0, rf_we, cp0_we, cp0_excp_valid, cp0_eret}, 64'd0);
            end else begin
                c = commit_q.pop_front();
                chk("rf_we", 64'(rf_we), 64'(c.rf_we));
                if (c.rf_we) begin
                    chk("rf_waddr", 64'(rf_waddr), 64'(c.waddr));
                    chk("rf_wdata", 64'(rf_wdata), 64'(c.wdata));
                end
                chk("cp0_we", 64'(cp0_we), 64'(c.cp0_we));
                if (c.chk_addr) chk("cp0_addr", 64'(cp0_addr), 64'(c.addr));
                if (c.cp0_we) chk("cp0_wdata", 64'(cp0_wdata), 64'(c.cwdata));
                chk("cp0_excp_valid", 64'(cp0_excp_valid), 64'(c.exc));
                if (c.exc) begin
                    chk("cp0_excode", 64'(cp0_excode), 64'(c.excode));
                    chk("cp0_pc", 64'(cp0_pc), 64'(c.pc));
                    chk("cp0_bd", 64'(cp0_bd), 64'(c.bd));
                end
                chk("cp0_eret", 64'(cp0_eret), 64'(c.eret));
            end
        end
        if (flush_o === 1'b1) begin
            if (flush_q.size() == 0) begin
                chk("unexpected_flush", 64'(flush_o), 64'd0);
            end else begin
                f = flush_q.pop_front();
                chk("flush_pc", 64'(flush_pc), 64'(f.pc));
                chk("excp_cnt", 64'(excp_cnt), 64'(f.cnt));
            end
        end
    end

    initial begin
        reset = 1'b1;
        cp0_rdata = 32'd0;
        ms_if.ms_to_ws_valid = 1'b0;
        set_ms(32'd0, 0, 0, 5'd0, 0, 0, 0, 8'd0, 5'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_cp0_we", 64'(cp0_we), 64'd0);
        chk("rst_excp", 64'(cp0_excp_valid), 64'd0);
        chk("rst_eret", 64'(cp0_eret), 64'd0);
        chk("rst_flush", 64'(flush_o), 64'd0);
        chk("rst_flush_pc", 64'(flush_pc), 64'd0);
        chk("rst_cnt", 64'(excp_cnt), 64'd0);
        chk("rst_allow_in", 64'(ms_if.ws_allow_in), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Plain ALU writeback.
        commit_q.push_back(mk(1, 5'd5, 32'h1234, 0, 0, 8'd0, 32'd0,
                              0, 5'd0, 32'd0, 0, 0));
        send(32'hbfc00000, 0, 0, 5'd0, 0, 0, 0, 8'd0, 5'd5, 32'h1234);
        idle(2);

        // Exception in delay slot.
        bump_cnt();
        commit_q.push_back(mk(0, 5'd0, 32'd0, 0, 0, 8'd0, 32'd0,
                              1, 5'h0c, 32'hbfc00010, 1, 0));
        flush_q.push_back(mkf(32'hbfc00380, exp_cnt));
        send(32'hbfc00010, 1, 1, 5'h0c, 0, 0, 0, 8'd0, 5'd3, 32'h77);
        idle(3);

        // MTC0 EPC immediately followed by ERET.
        commit_q.push_back(mk(0, 5'd0, 32'd0, 1, 1, 8'h70, 32'hbfc00100,
                              0, 5'd0, 32'd0, 0, 0));
        commit_q.push_back(mk(0, 5'd0, 32'd0, 0, 0, 8'd0, 32'd0,
                              0, 5'd0, 32'd0, 0, 1));
        flush_q.push_back(mkf(32'hbfc00100, exp_cnt));
        send(32'hbfc00020, 0, 0, 5'd0, 0, 1, 0, 8'h70, 5'd4, 32'hbfc00100);
        send(32'hbfc00024, 0, 0, 5'd0, 1, 0, 0, 8'd0, 5'd6, 32'h99);
        idle(3);

        // MFC0 returns cp0 read data.
        cp0_rdata = 32'h0000ff01;
        commit_q.push_back(mk(1, 5'd8, 32'h0000ff01, 0, 1, 8'h60, 32'd0,
                              0, 5'd0, 32'd0, 0, 0));
        send(32'hbfc00030, 0, 0, 5'd0, 0, 0, 1, 8'h60, 5'd8, 32'hdead);
        idle(2);

        // dest=0 produces no write.
        send(32'hbfc00034, 0, 0, 5'd0, 0, 0, 0, 8'd0, 5'd0, 32'h55);
        idle(2);

        // Exception with valid held: younger instrs (one an exception)
        // must be discarded, allow_in drops during the flush cycle.
        bump_cnt();
        commit_q.push_back(mk(0, 5'd0, 32'd0, 0, 0, 8'd0, 32'd0,
                              1, 5'h04, 32'hbfc00040, 0, 0));
        flush_q.push_back(mkf(32'hbfc00380, exp_cnt));
        set_ms(32'hbfc00040, 0, 1, 5'h04, 0, 0, 0, 8'd0, 5'd0, 32'd0);
        ms_if.ms_to_ws_valid = 1'b1;
        @(posedge clk); #1;
        set_ms(32'hbfc00044, 0, 1, 5'h08, 0, 0, 0, 8'd0, 5'd0, 32'd0);
        @(negedge clk);
        chk("allow_in_commit", 64'(ms_if.ws_allow_in), 64'd1);
        @(posedge clk); #1;
        set_ms(32'hbfc00048, 0, 0, 5'd0, 0, 0, 0, 8'd0, 5'd9, 32'h42);
        @(negedge clk);
        chk("allow_in_flush", 64'(ms_if.ws_allow_in), 64'd0);
        @(posedge clk); #1;
        ms_if.ms_to_ws_valid = 1'b0;
        idle(3);

        // Counter saturation.
        for (int i = 0; i < 16; i++) begin
            bump_cnt();
            commit_q.push_back(mk(0, 5'd0, 32'd0, 0, 0, 8'd0, 32'd0,
                                  1, 5'(i + 1), 32'hbfc00100 + 32'(i * 4),
                                  i[0], 0));
            flush_q.push_back(mkf(32'hbfc00380, exp_cnt));
            send(32'hbfc00100 + 32'(i * 4), i[0], 1, 5'(i + 1),
                 0, 0, 0, 8'd0, 5'd0, 32'd0);
            idle(3);
        end
        @(negedge clk);
        chk("cnt_saturated", 64'(excp_cnt), 64'(CMAX));
        @(posedge clk); #1;

        // Reset while flush_o is high.
        commit_q.push_back(mk(0, 5'd0, 32'd0, 0, 0, 8'd0, 32'd0,
                              1, 5'h0d, 32'hbfc00200, 0, 0));
        flush_q.push_back(mkf(32'hbfc00380, exp_cnt));
        send(32'hbfc00200, 0, 1, 5'h0d, 0, 0, 0, 8'd0, 5'd0, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rr_flush", 64'(flush_o), 64'd0);
        chk("rr_flush_pc", 64'(flush_pc), 64'd0);
        chk("rr_cnt", 64'(excp_cnt), 64'd0);
        chk("rr_strobes", {60'd0, rf_we, cp0_we, cp0_excp_valid, cp0_eret},
            64'd0);
        chk("rr_allow_in", 64'(ms_if.ws_allow_in), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = '0;

        // Normal operation resumes.
        commit_q.push_back(mk(1, 5'd1, 32'ha5a5, 0, 0, 8'd0, 32'd0,
                              0, 5'd0, 32'd0, 0, 0));
        send(32'hbfc00300, 0, 0, 5'd0, 0, 0, 0, 8'd0, 5'd1, 32'ha5a5);

        for (int n = 0; n < 20; n++) begin
            if (commit_q.size() == 0 && flush_q.size() == 0) break;
            @(posedge clk);
        end
        idle(2);
        chk("pending_commits", 64'(commit_q.size()), 64'd0);
        chk("pending_flushes", 64'(flush_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
